// File: rtl/i2c_master_ctrl.sv
// I2C master: runs complete register-file write or write-address/repeated-start/read transactions.
// Latency: one bit period is 4*CLK_DIV clk; busy rises the cycle after start, done pulses as busy falls.
// Backpressure: start is ignored while busy; wr_data must be valid in the wr_req cycle (no stall on the host side).
//
// Ports: clk/rst (async active-high); start/rw/dev_addr/reg_addr/len command, latched when idle;
//        wr_data/wr_req host write byte handshake; rd_data/rd_valid received bytes;
//        busy/done/nack_err status; scl_o/sda_oe/sda_i pad side.
// Optional macro I2C_CLK_STRETCH_EN: adds scl_i, SCL becomes open-drain (scl_o=1 means release),
//        and the phase counter freezes while SCL is released but held low by a slave.
module i2c_master_ctrl #(
    parameter int CLK_DIV = 4,
    parameter int MAX_LEN = 16,
    parameter int LEN_W   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             rw,
    input  logic [6:0]       dev_addr,
    input  logic [7:0]       reg_addr,
    input  logic [LEN_W-1:0] len,
    input  logic [7:0]       wr_data,
    output logic             wr_req,
    output logic [7:0]       rd_data,
    output logic             rd_valid,
    output logic             busy,
    output logic             done,
    output logic             nack_err,
    output logic             scl_o,
    output logic             sda_oe,
`ifdef I2C_CLK_STRETCH_EN
    input  logic             scl_i,
`endif
    input  logic             sda_i
);

    localparam int PH_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PH_W-1:0]  PH_LAST = PH_W'(CLK_DIV - 1);
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

    typedef enum logic [3:0] {
        S_IDLE, S_START, S_DEVW, S_ACK_D, S_REGA, S_ACK_R, S_WDATA,
        S_WACK, S_RSTART, S_DEVR, S_ACK_DR, S_RDATA, S_MACK, S_STOP
    } state_t;

    state_t           state_q, state_d;
    logic [PH_W-1:0]  ph_q;
    logic [1:0]       qtr_q;
    logic [2:0]       bit_q;
    logic [7:0]       sh_q;
    logic [LEN_W-1:0] cnt_q;
    logic             rw_q;
    logic [6:0]       dev_q;
    logic [7:0]       reg_q;
    logic [7:0]       rd_data_q;
    logic             rd_valid_q;
    logic             done_q;
    logic             nack_err_q;

    logic             stall;
    logic             accept;
    logic             bit_end;
    logic             samp;
    logic [LEN_W-1:0] len_clamp;

`ifdef I2C_CLK_STRETCH_EN
    // SCL released but still low on the pad: a slave is stretching the clock.
    assign stall = scl_o & ~scl_i;
`else
    assign stall = 1'b0;
`endif

    assign accept    = (state_q == S_IDLE) && start;
    assign bit_end   = !stall && (qtr_q == 2'd3) && (ph_q == PH_LAST);
    assign samp      = !stall && (qtr_q == 2'd3) && (ph_q == '0);
    assign len_clamp = (len == '0) ? LEN_ONE : ((len > LEN_MAX) ? LEN_MAX : len);

    assign busy     = (state_q != S_IDLE);
    assign done     = done_q;
    assign nack_err = nack_err_q;
    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic; every transition except IDLE->START happens at the end of a bit period
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start) state_d = S_START;
            S_START:  if (bit_end) state_d = S_DEVW;
            S_DEVW:   if (bit_end && bit_q == 3'd0) state_d = S_ACK_D;
            S_ACK_D:  if (bit_end) state_d = nack_err_q ? S_STOP : S_REGA;
            S_REGA:   if (bit_end && bit_q == 3'd0) state_d = S_ACK_R;
            S_ACK_R:  if (bit_end) state_d = nack_err_q ? S_STOP : (rw_q ? S_RSTART : S_WDATA);
            S_WDATA:  if (bit_end && bit_q == 3'd0) state_d = S_WACK;
            S_WACK:   if (bit_end) state_d = (nack_err_q || cnt_q == LEN_ONE) ? S_STOP : S_WDATA;
            S_RSTART: if (bit_end) state_d = S_DEVR;
            S_DEVR:   if (bit_end && bit_q == 3'd0) state_d = S_ACK_DR;
            S_ACK_DR: if (bit_end) state_d = nack_err_q ? S_STOP : S_RDATA;
            S_RDATA:  if (bit_end && bit_q == 3'd0) state_d = S_MACK;
            S_MACK:   if (bit_end) state_d = (cnt_q == LEN_ONE) ? S_STOP : S_RDATA;
            S_STOP:   if (bit_end) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Pad and handshake outputs, decoded from state and quarter
    always_comb begin
        wr_req = 1'b0;
        scl_o  = 1'b1;
        sda_oe = 1'b0;
        case (state_q)
            S_IDLE:   ;
            S_START:  sda_oe = qtr_q[1];
            S_RSTART: begin
                scl_o  = (qtr_q != 2'd0);
                sda_oe = qtr_q[1];
            end
            S_STOP: begin
                scl_o  = (qtr_q != 2'd0);
                sda_oe = !qtr_q[1];
            end
            S_DEVW, S_REGA, S_DEVR: begin
                scl_o  = qtr_q[1];
                sda_oe = !sh_q[7];
            end
            S_WDATA: begin
                scl_o  = qtr_q[1];
                wr_req = (bit_q == 3'd7) && (qtr_q == 2'd0) && (ph_q == '0);
                // The byte lands in sh_q only at the end of the wr_req cycle, so drive its MSB straight through.
                sda_oe = wr_req ? !wr_data[7] : !sh_q[7];
            end
            S_MACK: begin
                scl_o  = qtr_q[1];
                sda_oe = (cnt_q != LEN_ONE);
            end
            default:  scl_o = qtr_q[1];   // ACK slots and RDATA: SDA released
        endcase
    end

    // Datapath: command latch, bit timing, shift register, counters, status
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ph_q       <= '0;
            qtr_q      <= 2'd0;
            bit_q      <= 3'd7;
            sh_q       <= 8'h00;
            cnt_q      <= '0;
            rw_q       <= 1'b0;
            dev_q      <= 7'h00;
            reg_q      <= 8'h00;
            rd_data_q  <= 8'h00;
            rd_valid_q <= 1'b0;
            done_q     <= 1'b0;
            nack_err_q <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            if (accept) begin
                rw_q       <= rw;
                dev_q      <= dev_addr;
                reg_q      <= reg_addr;
                cnt_q      <= len_clamp;
                nack_err_q <= 1'b0;
                ph_q       <= '0;
                qtr_q      <= 2'd0;
                bit_q      <= 3'd7;
            end else if (state_q != S_IDLE && !stall) begin
                if (ph_q == PH_LAST) begin
                    ph_q  <= '0;
                    qtr_q <= qtr_q + 2'd1;
                end else begin
                    ph_q <= ph_q + 1'b1;
                end
            end

            if (wr_req) sh_q <= wr_data;

            if (samp) begin
                case (state_q)
                    S_ACK_D, S_ACK_R, S_WACK, S_ACK_DR: if (sda_i) nack_err_q <= 1'b1;
                    S_RDATA: begin
                        sh_q <= {sh_q[6:0], sda_i};
                        if (bit_q == 3'd0) begin
                            rd_data_q  <= {sh_q[6:0], sda_i};
                            rd_valid_q <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end

            if (bit_end) begin
                case (state_q)
                    S_START:  sh_q <= {dev_q, 1'b0};
                    S_RSTART: sh_q <= {dev_q, 1'b1};
                    S_ACK_D:  sh_q <= reg_q;
                    S_DEVW, S_REGA, S_WDATA, S_DEVR: begin
                        bit_q <= bit_q - 3'd1;   // wraps 0 -> 7 ready for the next byte
                        sh_q  <= {sh_q[6:0], 1'b0};
                    end
                    S_RDATA:  bit_q <= bit_q - 3'd1;
                    S_WACK, S_MACK: if (cnt_q != LEN_ONE) cnt_q <= cnt_q - 1'b1;
                    S_STOP:   done_q <= 1'b1;
                    default:  ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Bench for i2c_master_ctrl: table of complete transactions against a bus-level slave model,
// plus hand sequences for reset (idle and mid-byte) and, with I2C_CLK_STRETCH_EN, clock stretching.
module tb_i2c_master_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       rw;
    logic [6:0] dev_addr;
    logic [7:0] reg_addr;
    logic [4:0] len;
    logic [7:0] wr_data;
    logic       wr_req;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       busy;
    logic       done;
    logic       nack_err;
    logic       scl_o;
    logic       sda_oe;
    logic       sda_i;
    logic       slave_low = 1'b0;

    assign sda_i = ~(sda_oe | slave_low);

`ifdef I2C_CLK_STRETCH_EN
    logic scl_i;
    logic hold = 1'b0;
    int   stretch_left = 0;
    bit   stretch_arm = 1'b0;
    assign scl_i = scl_o & ~hold;
`endif

    always #5 clk = ~clk;

    i2c_master_ctrl #(.CLK_DIV(4), .MAX_LEN(16), .LEN_W(5)) dut (
        .clk(clk), .rst(rst), .start(start), .rw(rw), .dev_addr(dev_addr),
        .reg_addr(reg_addr), .len(len), .wr_data(wr_data), .wr_req(wr_req),
        .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy), .done(done),
        .nack_err(nack_err), .scl_o(scl_o), .sda_oe(sda_oe),
`ifdef I2C_CLK_STRETCH_EN
        .scl_i(scl_i),
`endif
        .sda_i(sda_i)
    );

    typedef struct {
        logic       rw;
        logic [6:0] dev;
        logic [7:0] rega;
        logic [4:0] len;
        logic       mid_start;   // pulse a conflicting start while busy
        int         cycles;      // busy cycles, hand-computed
        int         nbytes;      // master-driven bytes seen on the bus
        int         wreqs;
        int         rvlds;
        int         starts;      // START + RSTART conditions
        logic       nack;
    } vec_t;

    vec_t       tv[6];
    logic [7:0] wdat[17];
    logic [7:0] rbytes[3];

    int n_chk = 0;
    int n_pass = 0;

    // bus monitor / slave model state
    logic [7:0] bus_q[$];
    logic [7:0] rdq[$];
    logic       mack_q[$];
    int         n_starts, n_stops, bitn, frame, wr_idx;
    bit         rmode, bit_seen, rd_done, ack_now;
    logic [7:0] acc;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    // Slave model sampled on the falling clk edge: decodes START/STOP/bits, acks, returns read data.
    initial begin
        logic scl_p, sda_p, scl_n, sda_n;
        scl_p = 1'b1;
        sda_p = 1'b1;
        forever begin
            @(negedge clk);
            scl_n = scl_o;
            sda_n = sda_i;
            if (rd_valid) rdq.push_back(rd_data);
            if (scl_n && scl_p && sda_p && !sda_n) begin
                n_starts++;
                bitn = 0; frame = 0; rmode = 1'b0; bit_seen = 1'b0; acc = 8'h00;
            end else if (scl_n && scl_p && !sda_p && sda_n) begin
                n_stops++;
            end else if (scl_n && !scl_p) begin
                bit_seen = 1'b1;
                if (bitn < 8) acc = {acc[6:0], sda_n};
                else if (rmode && frame > 0) begin
                    mack_q.push_back(sda_n);
                    if (sda_n) rd_done = 1'b1;
                end
`ifdef I2C_CLK_STRETCH_EN
                if (stretch_arm && frame == 1 && bitn == 3) begin
                    stretch_arm  = 1'b0;
                    stretch_left = 20;
                end
`endif
            end else if (!scl_n && scl_p && bit_seen) begin
                bit_seen = 1'b0;
                if (bitn < 8) begin
                    bitn++;
                    if (bitn == 8 && !(rmode && frame > 0)) begin
                        bus_q.push_back(acc);
                        if (frame == 0) rmode = acc[0];
                        ack_now = (frame != 0) || (acc[7:1] == 7'h0A);
                    end
                end else begin
                    bitn = 0;
                    frame++;
                end
                if (rmode && frame > 0)
                    slave_low = (bitn < 8 && !rd_done && frame <= 3) ? ~rbytes[frame-1][7-bitn] : 1'b0;
                else
                    slave_low = (bitn == 8) ? ack_now : 1'b0;
            end
            scl_p = scl_n;
            sda_p = sda_n;
        end
    end

    // Host write-data source: present the next byte once the current one has been consumed.
    initial begin
        forever begin
            @(negedge clk);
            if (wr_req) begin
                @(posedge clk);
                #1;
                wr_idx++;
                if (wr_idx < 17) wr_data = wdat[wr_idx];
            end
        end
    end

`ifdef I2C_CLK_STRETCH_EN
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (stretch_left > 0) begin
                hold = 1'b1;
                stretch_left--;
            end else begin
                hold = 1'b0;
            end
        end
    end
`endif

    task automatic clear_model();
        bus_q.delete(); rdq.delete(); mack_q.delete();
        n_starts = 0; n_stops = 0; bitn = 0; frame = 0; wr_idx = 0;
        rmode = 1'b0; bit_seen = 1'b0; rd_done = 1'b0; ack_now = 1'b0;
        slave_low = 1'b0;
        wr_data = wdat[0];
    endtask

    task automatic launch(input int i);
        clear_model();
        rw = tv[i].rw; dev_addr = tv[i].dev; reg_addr = tv[i].rega; len = tv[i].len;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic run_txn(input int i, input int extra);
        int         cyc;
        logic [7:0] exp_b;
        launch(i);
        chk($sformatf("v%0d_busy_on_accept", i), busy, 1'b1);
        chk($sformatf("v%0d_nack_cleared_on_accept", i), nack_err, 1'b0);
        cyc = 0;
        while (busy && cyc < 6000) begin
            @(posedge clk);
            #1;
            cyc++;
            if (tv[i].mid_start && cyc == 100) begin
                rw = 1'b1; dev_addr = 7'h3F; reg_addr = 8'hEE; len = 5'd5; start = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        chk($sformatf("v%0d_cycles", i), cyc, tv[i].cycles + extra);
        chk($sformatf("v%0d_done_at_end", i), done, 1'b1);
        @(posedge clk);
        #1;
        chk($sformatf("v%0d_done_one_cycle", i), done, 1'b0);
        chk($sformatf("v%0d_nack_err", i), nack_err, tv[i].nack);
        chk($sformatf("v%0d_wr_req_count", i), wr_idx, tv[i].wreqs);
        chk($sformatf("v%0d_rd_valid_count", i), rdq.size(), tv[i].rvlds);
        chk($sformatf("v%0d_start_count", i), n_starts, tv[i].starts);
        chk($sformatf("v%0d_stop_count", i), n_stops, 1);
        chk($sformatf("v%0d_bus_byte_count", i), bus_q.size(), tv[i].nbytes);
        for (int k = 0; k < tv[i].nbytes; k++) begin
            if (k == 0)      exp_b = {tv[i].dev, 1'b0};
            else if (k == 1) exp_b = tv[i].rega;
            else if (tv[i].rw) exp_b = {tv[i].dev, 1'b1};
            else             exp_b = wdat[k-2];
            chk($sformatf("v%0d_bus_byte%0d", i, k), (k < bus_q.size()) ? bus_q[k] : 8'hxx, exp_b);
        end
        for (int k = 0; k < tv[i].rvlds; k++) begin
            chk($sformatf("v%0d_rd_data%0d", i, k), (k < rdq.size()) ? rdq[k] : 8'hxx, rbytes[k]);
            chk($sformatf("v%0d_mack%0d", i, k), (k < mack_q.size()) ? mack_q[k] : 1'bx,
                (k == tv[i].rvlds - 1) ? 1'b1 : 1'b0);
        end
    endtask

    initial begin
        bit seen;
        //        rw    dev    reg    len  mid   cyc  bytes wreq rvld starts nack
        tv[0] = '{1'b0, 7'h0A, 8'h12, 5'd2,  1'b0, 608,  4,  2,   0,   1,   1'b0};
        tv[1] = '{1'b1, 7'h0A, 8'h12, 5'd3,  1'b0, 912,  3,  0,   3,   2,   1'b0};
        tv[2] = '{1'b0, 7'h3F, 8'h12, 5'd2,  1'b0, 176,  1,  0,   0,   1,   1'b1};
        tv[3] = '{1'b0, 7'h0A, 8'h34, 5'd0,  1'b1, 464,  3,  1,   0,   1,   1'b0};
        tv[4] = '{1'b1, 7'h0A, 8'h56, 5'd0,  1'b0, 624,  3,  0,   1,   2,   1'b0};
        tv[5] = '{1'b0, 7'h0A, 8'h12, 5'd20, 1'b0, 2624, 18, 16,  0,   1,   1'b0};
        for (int k = 0; k < 17; k++) wdat[k] = 8'hAA + 8'(8'h11 * k);
        rbytes[0] = 8'h11; rbytes[1] = 8'h22; rbytes[2] = 8'h33;

        rst = 1'b1; start = 1'b0; rw = 1'b0; dev_addr = 7'h00; reg_addr = 8'h00; len = 5'd0;
        clear_model();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_scl_o", scl_o, 1'b1);
        chk("reset_sda_oe", sda_oe, 1'b0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 1'b0);
        chk("reset_nack_err", nack_err, 1'b0);
        chk("reset_wr_req", wr_req, 1'b0);
        chk("reset_rd_valid", rd_valid, 1'b0);
        chk("reset_rd_data", rd_data, 8'h00);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 6; i++) run_txn(i, 0);

        // Reset while idle with a sticky NACK and stale read data present
        run_txn(2, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("idle_rst_nack_err", nack_err, 1'b0);
        chk("idle_rst_rd_data", rd_data, 8'h00);
        chk("idle_rst_scl_o", scl_o, 1'b1);
        chk("idle_rst_busy", busy, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset in the first cycle of a data byte (SCL low), takes effect without waiting for a clock
        launch(0);
        seen = 1'b0;
        for (int k = 0; k < 1000 && !seen; k++) begin
            @(negedge clk);
            if (wr_req) seen = 1'b1;
        end
        chk("wdata_reached", seen, 1'b1);
        chk("wdata_scl_low_before_rst", scl_o, 1'b0);
        #1;
        rst = 1'b1;
        #1;
        chk("wdata_rst_scl_o", scl_o, 1'b1);
        chk("wdata_rst_sda_oe", sda_oe, 1'b0);
        chk("wdata_rst_busy", busy, 1'b0);
        chk("wdata_rst_wr_req", wr_req, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        run_txn(0, 0);

`ifdef I2C_CLK_STRETCH_EN
        stretch_arm = 1'b1;
        run_txn(0, 20);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/i2c_master_ctrl.md
Name: i2c_master_ctrl

Overview:
Parametrised, single-clock I2C master. Runs complete register-file transactions on command: multi-byte write, or combined write-address/repeated-start/read. Adds programmable device address, length, read support, slave-ACK checking and an internal SCL divider. Sits between the OTP controller command logic and the external I2C pads.

Parameters:
CLK_DIV, 4, clk cycles per SCL quarter-phase; bit period = 4*CLK_DIV clk; legal range >= 2
MAX_LEN, 16, maximum bytes per transaction
LEN_W, 5, width of len port; must satisfy 2^LEN_W > MAX_LEN

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
start  in  1  command strobe; sampled only when busy=0
rw  in  1  0 = write, 1 = read
dev_addr  in  7  slave device address
reg_addr  in  8  first register address
len  in  LEN_W  byte count; 0 treated as 1; values above MAX_LEN clamped to MAX_LEN
wr_data  in  8  write byte; must be valid in the cycle wr_req=1
wr_req  out  1  one-cycle pulse: wr_data consumed
rd_data  out  8  last received byte; held until next byte
rd_valid  out  1  one-cycle pulse: rd_data updated
busy  out  1  transaction in progress
done  out  1  one-cycle pulse at end of STOP
nack_err  out  1  sticky; slave NACK seen; cleared when next start is accepted
scl_o  out  1  SCL drive (push-pull, idle 1)
sda_oe  out  1  1 = pull SDA low, 0 = release
sda_i  in  1  SDA pad input

Behaviour:
- Reset values: scl_o=1, sda_oe=0, busy=0, done=0, nack_err=0, wr_req=0, rd_valid=0, rd_data=0, state=IDLE. Async reset takes effect immediately, including mid-transaction; no STOP is generated.
- Command latch: start=1 with busy=0 latches rw, dev_addr, reg_addr, len; busy=1 on the next cycle. start while busy=1 is ignored.
- Timing: a phase counter counts CLK_DIV clocks per quarter. Each data bit has four quarters:
  - q0, q1: SCL low; SDA updated at the start of q0.
  - q2, q3: SCL high; sda_i sampled at the start of q3.
- START: SDA released and SCL high for q0-q1; SDA driven low at q2; SCL falls at the end of q3.
- Repeated start (RSTART): SCL low with SDA released (q0), then SCL high (q1), then same as START.
- STOP: SDA low with SCL low (q0), SCL high (q1), SDA released (q2-q3). Then done=1 for one cycle and busy=0 in the same cycle.
- States: IDLE, START, DEVW, ACK_D, REGA, ACK_R, WDATA, WACK, RSTART, DEVR, ACK_DR, RDATA, MACK, STOP.
- Write path: IDLE > START > DEVW {dev_addr,0} > ACK_D > REGA > ACK_R > (WDATA > WACK) x len > STOP.
- Read path: IDLE > START > DEVW > ACK_D > REGA > ACK_R > RSTART > DEVR {dev_addr,1} > ACK_DR > (RDATA > MACK) x len > STOP.
- Bit order: MSB first. Master releases SDA during every ACK slot and during RDATA.
- wr_req pulses in the first cycle of WDATA bit 7; the byte is loaded into the shift register that cycle.
- rd_valid pulses one cycle after bit 0 is sampled.
- MACK: drives low (ACK) for bytes 1..len-1; releases (NACK) on the last byte.
- Slave NACK (sda_i=1 at q3) in any ACK_*/WACK slot: nack_err=1, go to STOP, no further bytes, done still pulses.
- Transaction length (clk): 4*CLK_DIV*(2 + 9*(2+len)) for write; 4*CLK_DIV*(3 + 9*(3+len)) for read.
- Counters: byte counter LEN_W bits, bit counter 3 bits down-count, no wrap beyond len.

Optional Feature:
- Macro: I2C_CLK_STRETCH_EN.
- Defined: adds input scl_i (SCL pad input) and drives SCL open-drain. While scl_o=1 and scl_i=0, the phase counter freezes. Counting resumes the cycle after scl_i=1.
- Undefined: no scl_i port; SCL is push-pull and timing is fixed.

Test Plan:
- Reset: assert rst for 3 clk mid-idle and mid-WDATA -> scl_o=1, sda_oe=0, busy=0, nack_err=0 within the same cycle.
- Write, CLK_DIV=4, dev 0x0A, reg 0x12, len=2, data 0xAA,0xBB, slave ACKs -> bytes on bus 0x14, 0x12, 0xAA, 0xBB; 2 wr_req pulses; done after 608 clk; nack_err=0.
- Read, dev 0x0A, reg 0x12, len=3, slave returns 0x11,0x22,0x33 -> bytes on bus 0x14, 0x12, RSTART, 0x15; rd_valid x3 with 0x11/0x22/0x33; MACK low, low, then released.
- NACK on device address (dev 0x3F) -> nack_err=1, STOP follows ACK_D directly, no 0x12 byte, done pulses; next start clears nack_err.
- start pulsed while busy, and len=0 -> second start ignored; len=0 transfers exactly 1 byte.
- I2C_CLK_STRETCH_EN defined: hold scl_i low 20 clk during REGA bit 4 q2 -> bit stretched by 20 clk; data is still 0x12.
